// File: rtl/cv32e40p_ft_pkg.sv
// Shared types and helpers for the triplicated fault-tolerant units.
// Holds the applied-mode encoding and the replica count.
package cv32e40p_ft_pkg;

  typedef enum logic [1:0] {
    FT_NORMAL   = 2'b00,
    FT_DEGRADED = 2'b01,
    FT_FAILED   = 2'b10
  } ft_mode_e;

  parameter int FT_N_REPLICA = 3;

  function automatic logic [1:0] ft_popcount(input logic [FT_N_REPLICA-1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  function automatic ft_mode_e ft_mode_of(input logic [FT_N_REPLICA-1:0] broken);
    case (ft_popcount(broken))
      2'd0:    return FT_NORMAL;
      2'd1:    return FT_DEGRADED;
      default: return FT_FAILED;
    endcase
  endfunction

endpackage

// File: rtl/cv32e40p_ft_breakage_cnt.sv
// Per-replica saturating breakage counter with threshold compare and sticky broken flag.
module cv32e40p_ft_breakage_cnt #(
  parameter int unsigned INCREMENT          = 1,
  parameter int unsigned DECREMENT          = 1,
  parameter int unsigned BREAKING_THRESHOLD = 3,
  parameter int unsigned COUNT_BIT          = 8,
  parameter int unsigned INC_DEC_BIT        = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 valid,
  input  logic                 mismatch,
  input  logic                 freeze,
  input  logic                 force_break,
  output logic [COUNT_BIT-1:0] cnt,
  output logic                 broken,
  output logic                 broken_next
);

  localparam logic [INC_DEC_BIT-1:0] IncStep = INC_DEC_BIT'(INCREMENT);
  localparam logic [INC_DEC_BIT-1:0] DecStep = INC_DEC_BIT'(DECREMENT);
  localparam logic [COUNT_BIT:0]     CntMax  = {1'b0, {COUNT_BIT{1'b1}}};
  localparam logic [COUNT_BIT:0]     Thr     = (COUNT_BIT + 1)'(BREAKING_THRESHOLD);

  logic [COUNT_BIT:0]   cnt_ext, inc_ext, dec_ext, sum;
  logic [COUNT_BIT-1:0] cnt_next;
  logic                 update;

  always_comb begin
    cnt_ext     = {1'b0, cnt};
    inc_ext     = (COUNT_BIT + 1)'(IncStep);
    dec_ext     = (COUNT_BIT + 1)'(DecStep);
    sum         = cnt_ext + inc_ext;
    update      = valid & ~freeze & ~broken;
    cnt_next    = cnt;
    if (update) begin
      if (mismatch) begin
        cnt_next = (sum > CntMax) ? CntMax[COUNT_BIT-1:0] : COUNT_BIT'(sum);
      end else begin
        cnt_next = (dec_ext > cnt_ext) ? '0 : COUNT_BIT'(cnt_ext - dec_ext);
      end
    end
    // Threshold is checked against the clamped, updated count.
    broken_next = broken | force_break | (update & ({1'b0, cnt_next} >= Thr));
    if (clear) begin
      cnt_next    = '0;
      broken_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      broken <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      broken <= broken_next;
    end
  end

endmodule

// File: rtl/cv32e40p_ft_tmr_ctrl.sv
// Breakage monitor and reconfiguration handshake for one triplicated unit.
// Optional mismatch event counter enabled by defining CV32E40P_FT_EVENT_CNT_EN.
module cv32e40p_ft_tmr_ctrl
  import cv32e40p_ft_pkg::*;
#(
  parameter int unsigned INCREMENT          = 1,
  parameter int unsigned DECREMENT          = 1,
  parameter int unsigned BREAKING_THRESHOLD = 3,
  parameter int unsigned COUNT_BIT          = 8,
  parameter int unsigned INC_DEC_BIT        = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              check_valid_i,
  input  logic [FT_N_REPLICA-1:0]           mismatch_i,
  input  logic                              clear_i,
  input  logic                              reconfig_ack_i,
  output logic [FT_N_REPLICA-1:0]           broken_o,
  output logic [FT_N_REPLICA-1:0]           sel_mask_o,
  output logic [1:0]                        mode_o,
  output logic                              reconfig_req_o,
  output logic                              fatal_o,
  output logic [FT_N_REPLICA*COUNT_BIT-1:0] cnt_o,
  output logic [31:0]                       event_cnt_o
);

  logic [FT_N_REPLICA-1:0] broken, broken_next, mask_q, mask_after;
  ft_mode_e                mode_q;
  logic                    req_q, fatal_q, ack_fire, apply, no_majority, freeze;

  // With no majority the voter cannot tell which replica is wrong, so all are condemned.
  assign no_majority = check_valid_i & (mode_q == FT_NORMAL) & (&mismatch_i);
  assign freeze      = (mode_q == FT_FAILED);

  for (genvar i = 0; i < FT_N_REPLICA; i++) begin : g_rep
    cv32e40p_ft_breakage_cnt #(
      .INCREMENT         (INCREMENT),
      .DECREMENT         (DECREMENT),
      .BREAKING_THRESHOLD(BREAKING_THRESHOLD),
      .COUNT_BIT         (COUNT_BIT),
      .INC_DEC_BIT       (INC_DEC_BIT)
    ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear_i),
      .valid      (check_valid_i),
      .mismatch   (mismatch_i[i]),
      .freeze     (freeze),
      .force_break(no_majority),
      .cnt        (cnt_o[i*COUNT_BIT +: COUNT_BIT]),
      .broken     (broken[i]),
      .broken_next(broken_next[i])
    );
  end

  assign ack_fire = reconfig_ack_i & req_q;
  assign apply    = ack_fire & (mode_q != FT_FAILED);

  // The mask taken at ack time is the pre-update broken vector.
  always_comb begin
    mask_after = mask_q;
    if (apply) mask_after = ~broken;
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      mode_q  <= FT_NORMAL;
      mask_q  <= '1;
      req_q   <= 1'b0;
      fatal_q <= 1'b0;
    end else begin
      if (apply) mode_q <= ft_mode_of(broken);
      mask_q  <= mask_after;
      req_q   <= (broken_next != ~mask_after);
      fatal_q <= (ft_popcount(broken_next) >= 2'd2);
    end
  end

`ifdef CV32E40P_FT_EVENT_CNT_EN
  logic [31:0] event_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      event_cnt_q <= '0;
    end else if (check_valid_i && (|mismatch_i) && (mode_q != FT_FAILED) &&
                 (event_cnt_q != '1)) begin
      event_cnt_q <= event_cnt_q + 32'd1;
    end
  end

  assign event_cnt_o = event_cnt_q;
`else
  assign event_cnt_o = '0;
`endif

  assign broken_o       = broken;
  assign sel_mask_o     = mask_q;
  assign mode_o         = mode_q;
  assign reconfig_req_o = req_q;
  assign fatal_o        = fatal_q;

endmodule

// File: tb/tb_cv32e40p_ft_tmr_ctrl.sv
// Directed self-checking bench for cv32e40p_ft_tmr_ctrl (default and small-counter builds).
module tb_cv32e40p_ft_tmr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_clear, a_ack;
  logic [2:0]  a_mism;
  logic [2:0]  a_broken, a_mask;
  logic [1:0]  a_mode;
  logic        a_req, a_fatal;
  logic [23:0] a_cnt;
  logic [31:0] a_ev;

  logic        b_valid, b_clear, b_ack;
  logic [2:0]  b_mism;
  logic [2:0]  b_broken, b_mask;
  logic [1:0]  b_mode;
  logic        b_req, b_fatal;
  logic [5:0]  b_cnt;
  logic [31:0] b_ev;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cv32e40p_ft_tmr_ctrl u_dut_a (
    .clk           (clk),
    .rst           (rst),
    .check_valid_i (a_valid),
    .mismatch_i    (a_mism),
    .clear_i       (a_clear),
    .reconfig_ack_i(a_ack),
    .broken_o      (a_broken),
    .sel_mask_o    (a_mask),
    .mode_o        (a_mode),
    .reconfig_req_o(a_req),
    .fatal_o       (a_fatal),
    .cnt_o         (a_cnt),
    .event_cnt_o   (a_ev)
  );

  cv32e40p_ft_tmr_ctrl #(
    .INCREMENT         (2),
    .DECREMENT         (1),
    .BREAKING_THRESHOLD(3),
    .COUNT_BIT         (2),
    .INC_DEC_BIT       (2)
  ) u_dut_b (
    .clk           (clk),
    .rst           (rst),
    .check_valid_i (b_valid),
    .mismatch_i    (b_mism),
    .clear_i       (b_clear),
    .reconfig_ack_i(b_ack),
    .broken_o      (b_broken),
    .sel_mask_o    (b_mask),
    .mode_o        (b_mode),
    .reconfig_req_o(b_req),
    .fatal_o       (b_fatal),
    .cnt_o         (b_cnt),
    .event_cnt_o   (b_ev)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 0; a_clear = 0; a_ack = 0; a_mism = 3'b000;
    b_valid = 0; b_clear = 0; b_ack = 0; b_mism = 3'b000;
    tick();
    tick();
    check("rst_mask", a_mask, 3'b111);
    check("rst_mode", a_mode, 2'b00);
    check("rst_broken", a_broken, 3'b000);
    check("rst_req", a_req, 1'b0);
    check("rst_fatal", a_fatal, 1'b0);
    check("rst_cnt", a_cnt, 24'h0);
    check("rst_ev", a_ev, 32'h0);
    check("rst_b_mask", b_mask, 3'b111);
    rst = 1'b0;

    // Ack with nothing pending is ignored.
    a_ack = 1; tick(); a_ack = 0;
    check("ack_idle_mask", a_mask, 3'b111);
    check("ack_idle_req", a_req, 1'b0);

    // Single fault on replica 0.
    a_valid = 1; a_mism = 3'b001;
    tick(); check("sf_cnt0_1", a_cnt[7:0], 8'd1);
    tick(); check("sf_cnt0_2", a_cnt[7:0], 8'd2);
    check("sf_broken_early", a_broken, 3'b000);
    tick(); check("sf_cnt0_3", a_cnt[7:0], 8'd3);
    check("sf_broken", a_broken, 3'b001);
    check("sf_req", a_req, 1'b1);
    check("sf_fatal", a_fatal, 1'b0);
    a_valid = 0; a_mism = 3'b000;
    tick(); tick();
    check("sf_req_hold", a_req, 1'b1);
    check("sf_mask_hold", a_mask, 3'b111);
`ifdef CV32E40P_FT_EVENT_CNT_EN
    check("sf_ev", a_ev, 32'd3);
`else
    check("sf_ev", a_ev, 32'd0);
`endif
    a_ack = 1; tick(); a_ack = 0;
    check("sf_ack_mask", a_mask, 3'b110);
    check("sf_ack_mode", a_mode, 2'b01);
    check("sf_ack_req", a_req, 1'b0);
    // Broken counter freezes.
    a_valid = 1; a_mism = 3'b000; tick(); a_valid = 0;
    check("sf_frozen", a_cnt[7:0], 8'd3);

    a_clear = 1; tick(); a_clear = 0;
    check("clr_mask", a_mask, 3'b111);
    check("clr_mode", a_mode, 2'b00);
    check("clr_cnt", a_cnt, 24'h0);
    check("clr_broken", a_broken, 3'b000);

    // Transient faults on replica 1.
    a_valid = 1;
    for (int i = 0; i < 20; i++) begin
      a_mism = (i % 2 == 0) ? 3'b010 : 3'b000;
      tick();
      check("tr_cnt1", a_cnt[15:8], (i % 2 == 0) ? 8'd1 : 8'd0);
    end
    a_mism = 3'b000; tick();
    check("tr_cnt1_floor", a_cnt[15:8], 8'd0);
    check("tr_broken", a_broken, 3'b000);
    check("tr_req", a_req, 1'b0);

    // No majority in NORMAL.
    a_mism = 3'b111; tick(); a_valid = 0; a_mism = 3'b000;
    check("nm_broken", a_broken, 3'b111);
    check("nm_fatal", a_fatal, 1'b1);
    check("nm_req", a_req, 1'b1);
    check("nm_cnt", a_cnt, 24'h010101);
    a_ack = 1; tick();
    check("nm_mode", a_mode, 2'b10);
    check("nm_mask", a_mask, 3'b000);
    check("nm_req_low", a_req, 1'b0);
    tick(); a_ack = 0;
    check("nm_absorb", a_mode, 2'b10);

    a_clear = 1; tick(); a_clear = 0;
    check("clr2_mode", a_mode, 2'b00);
    check("clr2_fatal", a_fatal, 1'b0);

    // Degraded, then failed.
    a_valid = 1; a_mism = 3'b001; tick(); tick(); tick();
    a_valid = 0; a_ack = 1; tick(); a_ack = 0;
    check("dg_mask", a_mask, 3'b110);
    a_valid = 1; a_mism = 3'b110; tick(); tick(); tick();
    check("dg_cnt", a_cnt, 24'h030303);
    check("dg_broken", a_broken, 3'b111);
    check("dg_fatal", a_fatal, 1'b1);
    check("dg_mode_wait", a_mode, 2'b01);
    check("dg_req", a_req, 1'b1);
    a_clear = 1; a_mism = 3'b001; tick(); a_clear = 0; a_valid = 0; a_mism = 3'b000;
    check("cp_cnt", a_cnt, 24'h0);
    check("cp_mask", a_mask, 3'b111);
    check("cp_mode", a_mode, 2'b00);
    check("cp_broken", a_broken, 3'b000);
    check("cp_req", a_req, 1'b0);
    check("cp_fatal", a_fatal, 1'b0);

    // Reset mid-handshake drops the pending request.
    a_valid = 1; a_mism = 3'b100; tick(); tick(); tick(); a_valid = 0; a_mism = 3'b000;
    check("rh_req", a_req, 1'b1);
    rst = 1; tick(); rst = 0;
    check("rh_req_low", a_req, 1'b0);
    check("rh_broken", a_broken, 3'b000);
    check("rh_cnt", a_cnt, 24'h0);

    // Small counter: saturation and ack coinciding with a new break.
    b_valid = 1; b_mism = 3'b001; tick();
    check("bs_cnt0_2", b_cnt[1:0], 2'd2);
    check("bs_broken0", b_broken, 3'b000);
    b_mism = 3'b011; tick();
    check("bs_cnt0_sat", b_cnt[1:0], 2'd3);
    check("bs_cnt1", b_cnt[3:2], 2'd2);
    check("bs_broken1", b_broken, 3'b001);
    check("bs_req", b_req, 1'b1);
    b_mism = 3'b010; b_ack = 1; tick();
    b_valid = 0; b_mism = 3'b000;
    check("bs_ack_broken", b_broken, 3'b011);
    check("bs_ack_mask", b_mask, 3'b110);
    check("bs_ack_mode", b_mode, 2'b01);
    check("bs_ack_req", b_req, 1'b1);
    check("bs_ack_fatal", b_fatal, 1'b1);
    tick(); b_ack = 0;
    check("bs_fail_mask", b_mask, 3'b100);
    check("bs_fail_mode", b_mode, 2'b10);
    check("bs_fail_req", b_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
